// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the LC-3b two-port memory
//               arbiter (FSM states, grantee codes, bank selects).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    // Byte address bit 0 selects the bank (little-endian: even byte = low bank)
    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_rr
// Description : Two-way round-robin picker; ptr names the favoured requester
//               when both request at once.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic ptr,
    output logic gnt_valid,
    output logic gnt
);

    always_comb begin
        gnt_valid = if_req | d_req;
        if (if_req && d_req) begin
            gnt = ptr;
        end else if (d_req) begin
            gnt = GNT_D;
        end else begin
            gnt = GNT_IF;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin fetch/data arbiter for the LC-3b hi/lo byte banks
//               with word/byte steering. Define MEM_ARB_STATS_EN to add
//               saturating grant/conflict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W:0]   if_addr,
    output logic              if_ack,
    output logic [15:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W:0]   d_addr,
    input  logic [15:0]       d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [15:0]       d_rdata,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [7:0]        hi_wdata,
    output logic [7:0]        lo_wdata,
    output logic              hi_write_n,
    output logic              lo_write_n,
    input  logic [7:0]        hi_rdata,
    input  logic [7:0]        lo_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       if_grants,
    output logic [15:0]       d_grants,
    output logic [15:0]       conflicts
`endif
);

    state_t      r_state;
    logic        r_ptr;
    logic        r_gnt;
    logic        r_we;
    logic        r_byte;
    logic        r_bsel;
    logic [2:0]  r_wcnt;
    logic [15:0] r_cap;

    logic            w_gnt_valid;
    logic            w_gnt;
    logic [ADDR_W:0] w_addr;
    logic            w_unaligned;
    logic            w_go_resp;
    logic [15:0]     w_rd;

    mem_arb_rr u_rr (
        .if_req    (if_req),
        .d_req     (d_req),
        .ptr       (r_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt       (w_gnt)
    );

    always_comb begin
        w_addr      = (w_gnt == GNT_D) ? d_addr : if_addr;
        w_unaligned = (w_gnt == GNT_D) && !d_byte && d_addr[0];
        w_go_resp   = ((r_state == ST_ACCESS) && (WAIT_CYC == 0)) ||
                      ((r_state == ST_WAIT) && (r_wcnt == 3'd0));
        // Live bank data straight out of ACCESS, captured copy after WAIT
        w_rd        = (r_state == ST_ACCESS) ? {hi_rdata, lo_rdata} : r_cap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= GNT_D;
            r_gnt      <= GNT_IF;
            r_we       <= 1'b0;
            r_byte     <= 1'b0;
            r_bsel     <= SEL_LO;
            r_wcnt     <= 3'd0;
            r_cap      <= 16'h0000;
            if_ack     <= 1'b0;
            if_rdata   <= 16'h0000;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= 16'h0000;
            bank_addr  <= '0;
            hi_wdata   <= 8'h00;
            lo_wdata   <= 8'h00;
            hi_write_n <= 1'b1;
            lo_write_n <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt  <= w_gnt;
                        r_we   <= (w_gnt == GNT_D) && d_we;
                        r_byte <= (w_gnt == GNT_D) && d_byte;
                        r_bsel <= w_addr[0];
                        if (w_unaligned) begin
                            d_ack   <= 1'b1;
                            d_err   <= 1'b1;
                            r_state <= ST_RESP;
                        end else begin
                            bank_addr <= w_addr[ADDR_W:1];
                            r_state   <= ST_ACCESS;
                            if ((w_gnt == GNT_D) && d_we) begin
                                if (d_byte) begin
                                    hi_wdata   <= d_wdata[7:0];
                                    lo_wdata   <= d_wdata[7:0];
                                    hi_write_n <= (d_addr[0] != SEL_HI);
                                    lo_write_n <= (d_addr[0] != SEL_LO);
                                end else begin
                                    hi_wdata   <= d_wdata[15:8];
                                    lo_wdata   <= d_wdata[7:0];
                                    hi_write_n <= 1'b0;
                                    lo_write_n <= 1'b0;
                                end
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    hi_write_n <= 1'b1;
                    lo_write_n <= 1'b1;
                    r_cap      <= {hi_rdata, lo_rdata};
                    if (WAIT_CYC > 0) begin
                        r_wcnt  <= 3'(WAIT_CYC - 1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wcnt != 3'd0) begin
                        r_wcnt <= r_wcnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    if_ack  <= 1'b0;
                    d_ack   <= 1'b0;
                    d_err   <= 1'b0;
                    r_ptr   <= (r_gnt == GNT_D) ? GNT_IF : GNT_D;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_go_resp) begin
                r_state <= ST_RESP;
                if (r_gnt == GNT_IF) begin
                    if_ack   <= 1'b1;
                    if_rdata <= w_rd;
                end else begin
                    d_ack <= 1'b1;
                    if (!r_we) begin
                        if (r_byte) begin
                            d_rdata <= {8'h00, (r_bsel == SEL_HI) ? w_rd[15:8] : w_rd[7:0]};
                        end else begin
                            d_rdata <= w_rd;
                        end
                    end
                end
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_grants <= 16'h0000;
            d_grants  <= 16'h0000;
            conflicts <= 16'h0000;
        end else if (r_state == ST_IDLE) begin
            if (w_gnt_valid && (w_gnt == GNT_IF) && (if_grants != 16'hFFFF)) begin
                if_grants <= if_grants + 16'd1;
            end
            if (w_gnt_valid && (w_gnt == GNT_D) && (d_grants != 16'hFFFF)) begin
                d_grants <= d_grants + 16'd1;
            end
            if (if_req && d_req && (conflicts != 16'hFFFF)) begin
                conflicts <= conflicts + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with negedge bank models
//               and a flat 512-byte reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, d_byte;
    logic [8:0]  if_addr, d_addr;
    logic [15:0] d_wdata;
    logic        if_ack, d_ack, d_err;
    logic [15:0] if_rdata, d_rdata;
    logic [7:0]  bank_addr, hi_wdata, lo_wdata;
    logic        hi_write_n, lo_write_n;
    logic [7:0]  hi_rdata, lo_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .WAIT_CYC(0)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .bank_addr(bank_addr), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .hi_write_n(hi_write_n), .lo_write_n(lo_write_n),
        .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
    );

    // Bank models: read and write on negedge, count write strobes
    logic [7:0] hi_mem [256];
    logic [7:0] lo_mem [256];
    int hi_wr = 0;
    int lo_wr = 0;

    initial begin
        for (int w = 0; w < 256; w++) begin
            hi_mem[w] = 8'($urandom);
            lo_mem[w] = 8'($urandom);
        end
        lo_mem[2]    = 8'h61; hi_mem[2]    = 8'h23;
        lo_mem[1]    = 8'h34; hi_mem[1]    = 8'h12;
        lo_mem[8'hFF] = 8'h56; hi_mem[8'hFF] = 8'h78;
        hi_rdata = 8'h00;
        lo_rdata = 8'h00;
        forever begin
            @(negedge clk);
            hi_rdata = hi_mem[bank_addr];
            lo_rdata = lo_mem[bank_addr];
            if (!hi_write_n) begin hi_mem[bank_addr] = hi_wdata; hi_wr++; end
            if (!lo_write_n) begin lo_mem[bank_addr] = lo_wdata; lo_wr++; end
        end
    end

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference memory: flat byte array, little-endian
    logic [7:0] ref_mem [512];

    function automatic logic [15:0] ref_word(input logic [8:0] a);
        return {ref_mem[{a[8:1], 1'b1}], ref_mem[{a[8:1], 1'b0}]};
    endfunction

    logic [15:0] res_rd;
    logic        res_err, res_other;
    logic [7:0]  res_ba;
    int          res_lat, res_hw, res_lw;

    task automatic do_access(input logic is_d, input logic we, input logic byt,
                             input logic [8:0] a, input logic [15:0] wd);
        int h0, l0;
        logic got;
        @(posedge clk); #1;
        h0 = hi_wr; l0 = lo_wr;
        d_we = we; d_byte = byt; d_addr = a; if_addr = a; d_wdata = wd;
        if (is_d) d_req = 1'b1; else if_req = 1'b1;
        res_lat = 0; got = 1'b0; res_ba = 8'h00;
        while (!got && res_lat < 20) begin
            @(negedge clk);
            res_lat++;
            if (res_lat == 2) res_ba = bank_addr;
            if (is_d ? d_ack : if_ack) begin
                got       = 1'b1;
                res_rd    = is_d ? d_rdata : if_rdata;
                res_err   = d_err;
                res_other = is_d ? if_ack : d_ack;
                if_req = 1'b0; d_req = 1'b0;
            end
        end
        if (!got) begin
            chk("ack_timeout", 32'd0, 32'd1);
            if_req = 1'b0; d_req = 1'b0;
        end
        @(posedge clk); #1;
        res_hw = hi_wr - h0;
        res_lw = lo_wr - l0;
    endtask

    typedef struct {
        logic        is_d, we, byt;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_err;
        int          exp_lat, exp_hw, exp_lw;
        logic [7:0]  exp_ba;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_d_rd, exp_if_rd, old20, v;
        logic [1:0]  ackv;
        logic        is_d, we, byt, err;
        logic [8:0]  a;
        logic [15:0] wd;

        //          is_d we  byt  addr    wdata    exp_rd   err lat hw lw ba
        tbl[0]  = '{1'b0,1'b0,1'b0,9'h004,16'h0000,16'h2361,1'b0,3,0,0,8'h02};
        tbl[1]  = '{1'b1,1'b1,1'b1,9'h011,16'h00A5,16'h0000,1'b0,3,1,0,8'h08};
        tbl[2]  = '{1'b1,1'b0,1'b1,9'h011,16'h0000,16'h00A5,1'b0,3,0,0,8'h08};
        tbl[3]  = '{1'b1,1'b1,1'b0,9'h010,16'hBEEF,16'h00A5,1'b0,3,1,1,8'h08};
        tbl[4]  = '{1'b1,1'b0,1'b0,9'h010,16'h0000,16'hBEEF,1'b0,3,0,0,8'h08};
        tbl[5]  = '{1'b1,1'b0,1'b1,9'h010,16'h0000,16'h00EF,1'b0,3,0,0,8'h08};
        tbl[6]  = '{1'b0,1'b0,1'b0,9'h011,16'h0000,16'hBEEF,1'b0,3,0,0,8'h08};
        tbl[7]  = '{1'b1,1'b0,1'b0,9'h003,16'h0000,16'h00EF,1'b1,2,0,0,8'h00};
        tbl[8]  = '{1'b1,1'b1,1'b0,9'h003,16'hFFFF,16'h00EF,1'b1,2,0,0,8'h00};
        tbl[9]  = '{1'b1,1'b0,1'b0,9'h002,16'h0000,16'h1234,1'b0,3,0,0,8'h01};
        tbl[10] = '{1'b1,1'b1,1'b1,9'h1FF,16'h1234,16'h1234,1'b0,3,1,0,8'hFF};
        tbl[11] = '{1'b1,1'b0,1'b1,9'h1FF,16'h0000,16'h0034,1'b0,3,0,0,8'hFF};
        tbl[12] = '{1'b1,1'b0,1'b0,9'h1FE,16'h0000,16'h3456,1'b0,3,0,0,8'hFF};
        tbl[13] = '{1'b1,1'b1,1'b1,9'h100,16'h00C3,16'h3456,1'b0,3,0,1,8'h80};
        tbl[14] = '{1'b1,1'b0,1'b1,9'h100,16'h0000,16'h00C3,1'b0,3,0,0,8'h80};

        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
        if_addr = 9'h000; d_addr = 9'h000; d_wdata = 16'h0000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_if_ack", {31'b0, if_ack}, 32'd0);
        chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
        chk("rst_d_err", {31'b0, d_err}, 32'd0);
        chk("rst_rdata", {if_rdata, d_rdata}, 32'd0);
        chk("rst_bank_addr", {24'b0, bank_addr}, 32'd0);
        chk("rst_wdata", {16'b0, hi_wdata, lo_wdata}, 32'd0);
        chk("rst_write_n", {30'b0, hi_write_n, lo_write_n}, 32'd3);

        for (int i = 0; i < 15; i++) begin
            do_access(tbl[i].is_d, tbl[i].we, tbl[i].byt, tbl[i].addr, tbl[i].wdata);
            chk($sformatf("vec%0d_rdata", i), {16'b0, res_rd}, {16'b0, tbl[i].exp_rd});
            chk($sformatf("vec%0d_err", i), {31'b0, res_err}, {31'b0, tbl[i].exp_err});
            chk($sformatf("vec%0d_lat", i), res_lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_hiwr", i), res_hw, tbl[i].exp_hw);
            chk($sformatf("vec%0d_lowr", i), res_lw, tbl[i].exp_lw);
            chk($sformatf("vec%0d_other_ack", i), {31'b0, res_other}, 32'd0);
            if (!tbl[i].exp_err)
                chk($sformatf("vec%0d_bank_addr", i), {24'b0, res_ba}, {24'b0, tbl[i].exp_ba});
        end

        // Reference memory mirrors bank contents from here on
        for (int w = 0; w < 256; w++) begin
            ref_mem[2*w]   = lo_mem[w];
            ref_mem[2*w+1] = hi_mem[w];
        end

        // Reset while a word store is in its ACCESS cycle
        old20 = ref_word(9'h020);
        @(posedge clk); #1;
        d_we = 1'b1; d_byte = 1'b0; d_addr = 9'h020; d_wdata = 16'hCAFE; d_req = 1'b1;
        @(posedge clk); #2;
        chk("rstacc_write_active", {30'b0, hi_write_n, lo_write_n}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rstacc_write_n", {30'b0, hi_write_n, lo_write_n}, 32'd3);
        chk("rstacc_bank_addr", {24'b0, bank_addr}, 32'd0);
        chk("rstacc_wdata", {16'b0, hi_wdata, lo_wdata}, 32'd0);
        chk("rstacc_rdata", {if_rdata, d_rdata}, 32'd0);
        chk("rstacc_acks", {30'b0, if_ack, d_ack}, 32'd0);
        d_req = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        do_access(1'b1, 1'b0, 1'b0, 9'h020, 16'h0000);
        chk("rstacc_reload", {16'b0, res_rd}, {16'b0, old20});
        chk("rstacc_reload_lat", res_lat, 3);

        // Contention from reset: data first, then strict alternation
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        d_we = 1'b0; d_byte = 1'b0; d_addr = 9'h010; if_addr = 9'h004;
        d_req = 1'b1; if_req = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            ackv = 2'b00;
            if (n == 3 || n == 9) ackv = 2'b01;
            if (n == 6 || n == 12) ackv = 2'b10;
            chk($sformatf("rr_acks_c%0d", n), {30'b0, if_ack, d_ack}, {30'b0, ackv});
            if (ackv == 2'b01) chk($sformatf("rr_d_rdata_c%0d", n), {16'b0, d_rdata}, {16'b0, ref_word(9'h010)});
            if (ackv == 2'b10) chk($sformatf("rr_if_rdata_c%0d", n), {16'b0, if_rdata}, {16'b0, ref_word(9'h004)});
        end
        @(negedge clk);
        d_req = 1'b0; if_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rr_quiet", {30'b0, if_ack, d_ack}, 32'd0);
        end
        exp_d_rd  = ref_word(9'h010);
        exp_if_rd = ref_word(9'h004);

        // Randomized accesses against the flat-memory model
        for (int k = 0; k < 150; k++) begin
            is_d = ($urandom_range(0, 2) != 0);
            we   = is_d & 1'($urandom);
            byt  = is_d & 1'($urandom);
            a    = 9'($urandom);
            wd   = 16'($urandom);
            err  = is_d && !byt && a[0];
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_access(is_d, we, byt, a, wd);
            chk($sformatf("rnd%0d_err", k), {31'b0, res_err}, {31'b0, err});
            chk($sformatf("rnd%0d_lat", k), res_lat, err ? 2 : 3);
            if (!is_d) begin
                exp_if_rd = ref_word(a);
                chk($sformatf("rnd%0d_if_rdata", k), {16'b0, res_rd}, {16'b0, exp_if_rd});
                chk($sformatf("rnd%0d_writes", k), res_hw + res_lw, 0);
            end else begin
                if (err || we) begin
                    v = exp_d_rd;
                end else begin
                    v = byt ? {8'h00, ref_mem[a]} : ref_word(a);
                end
                exp_d_rd = v;
                chk($sformatf("rnd%0d_d_rdata", k), {16'b0, res_rd}, {16'b0, exp_d_rd});
                if (!err && we) begin
                    if (byt) begin
                        ref_mem[a] = wd[7:0];
                        chk($sformatf("rnd%0d_hiwr", k), res_hw, a[0] ? 1 : 0);
                        chk($sformatf("rnd%0d_lowr", k), res_lw, a[0] ? 0 : 1);
                    end else begin
                        ref_mem[a]        = wd[7:0];
                        ref_mem[a + 9'd1] = wd[15:8];
                        chk($sformatf("rnd%0d_hiwr", k), res_hw, 1);
                        chk($sformatf("rnd%0d_lowr", k), res_lw, 1);
                    end
                end else begin
                    chk($sformatf("rnd%0d_writes", k), res_hw + res_lw, 0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
